// File: rtl/adc_power_sequencer.sv
// ADC front-end power sequencer: ordered rail bring-up, single AXIS init beat, reverse power-down.
// Define ADC_SEQ_TIMEOUT_EN to add an AXIS handshake timeout that ends in the FAULT state.
module adc_power_sequencer #(
  parameter int DLY_W    = 16,
  parameter int PWR_DLY  = 1000,
  parameter int REF_DLY  = 1000,
  parameter int IO_DLY   = 100,
  parameter int AMP_DLY  = 1000,
  parameter int RST_DLY  = 100,
  parameter int DOWN_DLY = 100,
  parameter int TIMEOUT  = 4096
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] init_word,
  output logic        pwr_en,
  output logic        ref_en,
  output logic        io_en,
  output logic        diffamp_en,
  output logic        opamp_en,
  output logic        adc_resetn,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        ready,
  output logic        busy,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_PWR = 4'd1, ST_REF = 4'd2, ST_IO = 4'd3, ST_AMP = 4'd4,
    ST_RST = 4'd5, ST_CFG = 4'd6, ST_READY = 4'd7, ST_PD_RST = 4'd8, ST_PD_AMP = 4'd9,
    ST_PD_IO = 4'd10, ST_PD_REF = 4'd11, ST_PD_PWR = 4'd12, ST_FAULT = 4'd13
  } state_t;

  typedef struct packed {
    logic pwr;
    logic vref;
    logic io;
    logic amp;
    logic rstn;
  } rails_t;

  localparam logic [DLY_W-1:0] PWR_D  = DLY_W'(PWR_DLY);
  localparam logic [DLY_W-1:0] REF_D  = DLY_W'(REF_DLY);
  localparam logic [DLY_W-1:0] IO_D   = DLY_W'(IO_DLY);
  localparam logic [DLY_W-1:0] AMP_D  = DLY_W'(AMP_DLY);
  localparam logic [DLY_W-1:0] RST_D  = DLY_W'(RST_DLY);
  localparam logic [DLY_W-1:0] DOWN_D = DLY_W'(DOWN_DLY);
  localparam longint DLY_LIM = longint'(1) << DLY_W;

  if (DLY_W < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("adc_power_sequencer: DLY_W and TIMEOUT must be at least 1");
  end
  if (PWR_DLY >= DLY_LIM || REF_DLY >= DLY_LIM || IO_DLY >= DLY_LIM ||
      AMP_DLY >= DLY_LIM || RST_DLY >= DLY_LIM || DOWN_DLY >= DLY_LIM) begin : g_dly_trunc
    $warning("adc_power_sequencer: a settling delay exceeds DLY_W bits and is truncated");
  end

  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d, tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d, ready_q, ready_d, busy_q, busy_d;
  rails_t           rails_q, rails_d;
  logic             expire;
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]  to_q, to_d;
  logic             fault_q, fault_d;
`endif

  function automatic logic [DLY_W-1:0] entry_dly(input state_t s);
    case (s)
      ST_PWR:  return PWR_D;
      ST_REF:  return REF_D;
      ST_IO:   return IO_D;
      ST_AMP:  return AMP_D;
      ST_RST:  return RST_D;
      ST_PD_RST, ST_PD_AMP, ST_PD_IO, ST_PD_REF, ST_PD_PWR: return DOWN_D;
      default: return '0;
    endcase
  endfunction

  // A delay of 0 or 1 both give a one-cycle dwell.
  assign expire = (cnt_q <= DLY_W'(1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - DLY_W'(1) : '0;
    word_d   = word_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    rails_d  = rails_q;
`ifdef ADC_SEQ_TIMEOUT_EN
    to_d     = to_q;
    fault_d  = fault_q;
`endif

    case (state_q)
      ST_IDLE, ST_FAULT: if (start && !stop) begin
        state_d = ST_PWR;
        word_d  = init_word;
`ifdef ADC_SEQ_TIMEOUT_EN
        fault_d = 1'b0;
`endif
      end
      ST_PWR:   if (stop) state_d = ST_PD_RST; else if (expire) state_d = ST_REF;
      ST_REF:   if (stop) state_d = ST_PD_RST; else if (expire) state_d = ST_IO;
      ST_IO:    if (stop) state_d = ST_PD_RST; else if (expire) state_d = ST_AMP;
      ST_AMP:   if (stop) state_d = ST_PD_RST; else if (expire) state_d = ST_RST;
      ST_RST:   if (stop) state_d = ST_PD_RST; else if (expire) state_d = ST_CFG;
      ST_CFG: begin
        // tvalid low while still in CFG means the beat went out last cycle.
        if (stop) begin
          state_d  = ST_PD_RST;
          tvalid_d = 1'b0;
        end else if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
        end else if (!tvalid_q) begin
          state_d = ST_READY;
`ifdef ADC_SEQ_TIMEOUT_EN
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d  = ST_PD_RST;
          tvalid_d = 1'b0;
          fault_d  = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
`endif
        end
      end
      ST_READY:  if (stop) state_d = ST_PD_RST;
      ST_PD_RST: if (expire) state_d = ST_PD_AMP;
      ST_PD_AMP: if (expire) state_d = ST_PD_IO;
      ST_PD_IO:  if (expire) state_d = ST_PD_REF;
      ST_PD_REF: if (expire) state_d = ST_PD_PWR;
`ifdef ADC_SEQ_TIMEOUT_EN
      ST_PD_PWR: if (expire) state_d = fault_q ? ST_FAULT : ST_IDLE;
`else
      ST_PD_PWR: if (expire) state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = entry_dly(state_d);
`ifdef ADC_SEQ_TIMEOUT_EN
      to_d  = '0;
`endif
      if (state_d == ST_CFG) begin
        tvalid_d = 1'b1;
        tdata_d  = word_q;
      end
    end

    // Rails are driven from the next state so each enable changes in the first cycle of its state.
    case (state_d)
      ST_IDLE, ST_FAULT: rails_d = '0;
      ST_PWR:    rails_d.pwr  = 1'b1;
      ST_REF:    rails_d.vref = 1'b1;
      ST_IO:     rails_d.io   = 1'b1;
      ST_AMP:    rails_d.amp  = 1'b1;
      ST_RST:    rails_d.rstn = 1'b1;
      ST_PD_RST: rails_d.rstn = 1'b0;
      ST_PD_AMP: rails_d.amp  = 1'b0;
      ST_PD_IO:  rails_d.io   = 1'b0;
      ST_PD_REF: rails_d.vref = 1'b0;
      ST_PD_PWR: rails_d.pwr  = 1'b0;
      default:   ;
    endcase

    ready_d = (state_d == ST_READY);
    busy_d  = !(state_d inside {ST_IDLE, ST_READY, ST_FAULT});
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      rails_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      to_q     <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      rails_q  <= rails_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef ADC_SEQ_TIMEOUT_EN
      to_q     <= to_d;
      fault_q  <= fault_d;
`endif
    end
  end

  assign pwr_en        = rails_q.pwr;
  assign ref_en        = rails_q.vref;
  assign io_en         = rails_q.io;
  assign diffamp_en    = rails_q.amp;
  assign opamp_en      = rails_q.amp;
  assign adc_resetn    = rails_q.rstn;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign ready         = ready_q;
  assign busy          = busy_q;
  assign state         = state_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign fault         = fault_q;
`else
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_adc_power_sequencer.sv
// Directed bench for adc_power_sequencer with short delays (4 per up-step, 2 per down-step).
// Cycle numbers count from the cycle in which start is high (cycle 0).
module tb_adc_power_sequencer;
  localparam int DLY  = 4;
  localparam int DDLY = 2;
  localparam int TMO  = 8;
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int STALL = 6;
`else
  localparam int STALL = 10;
`endif

  logic        aclk = 1'b0;
  logic        areset, start, stop, m_axis_tready;
  logic [31:0] init_word;
  logic        pwr_en, ref_en, io_en, diffamp_en, opamp_en, adc_resetn;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, ready, busy, fault;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int beats0   = 0;

  adc_power_sequencer #(
    .DLY_W(16), .PWR_DLY(DLY), .REF_DLY(DLY), .IO_DLY(DLY), .AMP_DLY(DLY),
    .RST_DLY(DLY), .DOWN_DLY(DDLY), .TIMEOUT(TMO)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop), .init_word(init_word),
    .pwr_en(pwr_en), .ref_en(ref_en), .io_en(io_en), .diffamp_en(diffamp_en),
    .opamp_en(opamp_en), .adc_resetn(adc_resetn), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .ready(ready),
    .busy(busy), .fault(fault), .state(state)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (m_axis_tvalid && m_axis_tready) beats++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  // {pwr, ref, io, diffamp, opamp, adc_resetn}
  function automatic logic [5:0] rails();
    return {pwr_en, ref_en, io_en, diffamp_en, opamp_en, adc_resetn};
  endfunction

  // Expected state k cycles after a stop (or timeout) enters the power-down chain.
  function automatic logic [3:0] pd_state(input int k);
    if (k < 3) return 4'd8;
    if (k < 5) return 4'd9;
    if (k < 7) return 4'd10;
    if (k < 9) return 4'd11;
    if (k < 11) return 4'd12;
    return 4'd0;
  endfunction

  initial begin
    areset = 1'b1; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b0; init_word = '0;
    repeat (3) tick();
    check("reset state", 32'(state), 32'd0);
    check("reset rails", 32'(rails()), 32'd0);
    check("reset tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset tdata", m_axis_tdata, 32'd0);
    check("reset flags", 32'({ready, busy, fault}), 32'd0);
    areset = 1'b0;
    tick();

    // Power-up with tready high; start during IO and a post-accept init_word change must be ignored.
    init_word = 32'hA5A5_0001; m_axis_tready = 1'b1; beats0 = beats;
    start = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (c == 1) begin start = 1'b0; init_word = 32'hDEAD_BEEF; end
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      check($sformatf("up c%0d rails", c), 32'(rails()),
            32'({c >= 1, c >= 5, c >= 9, c >= 13, c >= 13, c >= 17}));
      check($sformatf("up c%0d tvalid", c), 32'(m_axis_tvalid), 32'(c == 21));
      check($sformatf("up c%0d ready", c), 32'(ready), 32'(c >= 23));
      check($sformatf("up c%0d busy", c), 32'(busy), 32'(c <= 22));
      if (c == 21) check("up tdata", m_axis_tdata, 32'hA5A5_0001);
      case (c)
        1: check("up st PWR", 32'(state), 32'd1);
        5: check("up st REF", 32'(state), 32'd2);
        9: check("up st IO", 32'(state), 32'd3);
        13: check("up st AMP", 32'(state), 32'd4);
        17: check("up st RST", 32'(state), 32'd5);
        21: check("up st CFG", 32'(state), 32'd6);
        23: check("up st READY", 32'(state), 32'd7);
        default: ;
      endcase
    end
    check("up beats", 32'(beats - beats0), 32'd1);

    // Power-down from READY: rails fall in reverse order, two cycles apart.
    stop = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) stop = 1'b0;
      check($sformatf("pd k%0d rails", k), 32'(rails()),
            32'({k < 9, k < 7, k < 5, k < 3, k < 3, 1'b0}));
      check($sformatf("pd k%0d state", k), 32'(state), 32'(pd_state(k)));
      check($sformatf("pd k%0d busy", k), 32'(busy), 32'(k <= 10));
    end

    // tready held low: tvalid/tdata stay stable, exactly one beat, then READY.
    init_word = 32'h1234_5678; m_axis_tready = 1'b0; beats0 = beats;
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 1) begin start = 1'b0; init_word = 32'h0BAD_F00D; end
    end
    for (int s = 0; s < STALL; s++) begin
      check($sformatf("stall s%0d tvalid", s), 32'(m_axis_tvalid), 32'd1);
      check($sformatf("stall s%0d tdata", s), m_axis_tdata, 32'h1234_5678);
      check($sformatf("stall s%0d state", s), 32'(state), 32'd6);
      tick();
    end
    m_axis_tready = 1'b1;
    check("hs tvalid", 32'(m_axis_tvalid), 32'd1);
    tick();
    check("hs+1 tvalid", 32'(m_axis_tvalid), 32'd0);
    check("hs+1 ready", 32'(ready), 32'd0);
    check("hs beats", 32'(beats - beats0), 32'd1);
    tick();
    check("hs+2 ready", 32'(ready), 32'd1);
    check("hs+2 state", 32'(state), 32'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready ignores start", 32'(state), 32'd7);
    stop = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) stop = 1'b0;
    end
    check("stall pd idle", 32'(state), 32'd0);
    check("stall beats", 32'(beats - beats0), 32'd1);

    // Stop during REF aborts; start during power-down is ignored; no AXIS beat.
    beats0 = beats;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    check("abort st REF", 32'(state), 32'd2);
    stop = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) stop = 1'b0;
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      check($sformatf("abort k%0d rails", k), 32'(rails()),
            32'({k < 9, k < 7, 4'b0000}));
      check($sformatf("abort k%0d state", k), 32'(state), 32'(pd_state(k)));
      check($sformatf("abort k%0d tvalid", k), 32'(m_axis_tvalid), 32'd0);
    end
    check("abort beats", 32'(beats - beats0), 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start+stop idle state", 32'(state), 32'd0);
    check("start+stop idle busy", 32'(busy), 32'd0);
    check("start+stop idle rails", 32'(rails()), 32'd0);

    // Asynchronous reset mid-AMP clears everything before the next clock edge.
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    check("amp rails", 32'(rails()), 32'(6'b111110));
    #2 areset = 1'b1;
    #1;
    check("async rst state", 32'(state), 32'd0);
    check("async rst rails", 32'(rails()), 32'd0);
    check("async rst axis", 32'({m_axis_tvalid, m_axis_tdata}), 32'd0);
    check("async rst tdata", m_axis_tdata, 32'd0);
    check("async rst flags", 32'({ready, busy, fault}), 32'd0);
    tick();
    areset = 1'b0;
    tick();
    check("post rst state", 32'(state), 32'd0);

`ifdef ADC_SEQ_TIMEOUT_EN
    // Handshake timeout: fault after TMO stalled cycles, full power-down, park in FAULT.
    m_axis_tready = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c >= 20) begin
        check($sformatf("tmo c%0d fault", c), 32'(fault), 32'(c >= 29));
        check($sformatf("tmo c%0d tvalid", c), 32'(m_axis_tvalid), 32'(c >= 21 && c < 29));
      end
      case (c)
        28: check("tmo st CFG", 32'(state), 32'd6);
        29: check("tmo st PD_RST", 32'(state), 32'd8);
        38: check("tmo st PD_PWR", 32'(state), 32'd12);
        39: check("tmo st FAULT", 32'(state), 32'd13);
        default: ;
      endcase
    end
    check("fault rails", 32'(rails()), 32'd0);
    check("fault busy", 32'(busy), 32'd0);
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fault cleared", 32'(fault), 32'd0);
    check("fault restart", 32'(state), 32'd1);
`else
    // Without the timeout, CFG waits indefinitely and fault stays low.
    m_axis_tready = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    check("wait st CFG", 32'(state), 32'd6);
    check("wait tvalid", 32'(m_axis_tvalid), 32'd1);
    check("wait fault", 32'(fault), 32'd0);
`endif
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_power_sequencer.md
Name: adc_power_sequencer

Overview:
Sequences the ADC front-end analog rails and ADC reset through a fixed power-up order with per-step settling delays. After the last rail settles it releases ADC reset and sends one initialisation word to the ADC over AXI4-Stream. On request it runs the reverse power-down order. Sits between the AXI-Lite config block (start/stop, init word, status) and the ADC enable pins and ADC AXIS config input.

Parameters:
DLY_W, 16, width of settling counter
PWR_DLY, 1000, cycles after pwr_en before next step
REF_DLY, 1000, cycles after ref_en
IO_DLY, 100, cycles after io_en
AMP_DLY, 1000, cycles after diffamp_en/opamp_en
RST_DLY, 100, cycles after adc_resetn release before config word
DOWN_DLY, 100, cycles between each power-down step
TIMEOUT, 4096, AXIS handshake timeout cycles (only with ADC_SEQ_TIMEOUT_EN)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
start  in  1  single-cycle power-up request
stop  in  1  single-cycle power-down request
init_word  in  32  ADC init word, sampled when start is accepted
pwr_en  out  1  main rail enable
ref_en  out  1  reference enable
io_en  out  1  IO supply enable
diffamp_en  out  1  differential amp enable
opamp_en  out  1  op-amp enable
adc_resetn  out  1  ADC reset, active-low
m_axis_tdata  out  32  init word to ADC
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
ready  out  1  powered and configured
busy  out  1  sequence in progress
fault  out  1  handshake timeout (sticky until next start)
state  out  4  current state encoding, for status register

Behaviour:
- Reset (areset high, asynchronous): state=IDLE, all enables 0, adc_resetn 0, m_axis_tvalid 0, m_axis_tdata 0, ready/busy/fault 0, counter 0.
- All outputs registered. Timed states: on entry load counter with delay D; dwell max(D,1) cycles, then advance.
- States/encodings: IDLE 0, PWR 1, REF 2, IO 3, AMP 4, RST 5, CFG 6, READY 7, PD_RST 8, PD_AMP 9, PD_IO 10, PD_REF 11, PD_PWR 12, FAULT 13.
- IDLE: start (stop low) -> PWR, latch init_word, clear fault. start & stop same cycle -> stay IDLE.
- Power-up: PWR sets pwr_en; REF adds ref_en; IO adds io_en; AMP adds diffamp_en and opamp_en same cycle; RST sets adc_resetn=1. Each enable asserted in the first cycle of its state and held.
- CFG: m_axis_tvalid=1, tdata=latched word; hold both stable until tvalid&tready; next cycle tvalid=0, state READY. Single beat only.
- READY: ready=1, busy=0. start ignored. stop -> PD_RST.
- busy=1 in every state except IDLE, READY, FAULT.
- stop in any state PWR..CFG aborts immediately to PD_RST (tvalid dropped, word not sent). start while busy ignored.
- Power-down: PD_RST adc_resetn=0; PD_AMP amps=0; PD_IO io_en=0; PD_REF ref_en=0; PD_PWR pwr_en=0; each dwells DOWN_DLY, full chain always run even if rails were never on; then IDLE. start/stop ignored during power-down.
- Counter decrements saturating at 0; delays wider than DLY_W truncated (implementer checks at elaboration).

Optional Feature:
ADC_SEQ_TIMEOUT_EN: when defined, CFG counts cycles with tvalid high and tready low; reaching TIMEOUT -> fault=1, tvalid=0, then PD_RST and full power-down, ending in FAULT (not IDLE). FAULT behaves as IDLE for start; fault clears on accepted start. Without macro CFG waits indefinitely, FAULT unreachable, fault tied 0.

Test Plan:
- All delays=4, DOWN_DLY=2, start, tready=1 -> pwr_en@+1, ref_en@+5, io_en@+9, amps@+13, adc_resetn@+17, tvalid@+21 with latched init_word=0xA5A5_0001, ready@+23.
- tready low 10 cycles in CFG -> tvalid and tdata stable 10 cycles, single beat on tready, then READY.
- stop during REF -> next cycle PD_RST; enables fall in order adc_resetn, amps, io, ref, pwr, 2 cycles apart; IDLE, no AXIS beat.
- start during IO and start+stop in IDLE -> both ignored; init_word change after accept does not change tdata.
- areset pulse mid-AMP -> all outputs 0 immediately (asynchronous), state 0.
- Macro on, TIMEOUT=8, tready=0 -> fault=1 after 8 cycles, power-down, state 13; new start clears fault.
